// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the DataMem arbiter: word width and FSM state codes.
package data_mem_arbiter_pkg;

   // DataMem word width; the arbiter data path must match it.
   localparam int unsigned COL = 16;

   // Two-bit state code; 2'b11 is unused and recovers to ARB_IDLE.
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_ACCESS = 2'b01,
      ARB_RESP   = 2'b10
   } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Combinational two-way pick between the requesters.
// On a tie, round-robin favours the port not served last; fixed mode favours port 0.
module rr_arbiter_2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_served,
   input  logic i_rr_en,
   output logic o_grant_valid,
   output logic o_grant_idx
);

   // Winner selection from the current requests and the last served port.
   always_comb begin
      o_grant_valid = i_req0 | i_req1;
      o_grant_idx   = 1'b0;
      if (i_req0 && i_req1) begin
         o_grant_idx = i_rr_en ? ~i_last_served : 1'b0;
      end else if (i_req1) begin
         o_grant_idx = 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port req/ack sequencer sharing one DataMem: IDLE -> ACCESS -> RESP.
// One memory access per 3 cycles; ack pulses in RESP for the granted port.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = COL,
   parameter int unsigned ADDR_W = 16,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic              r_cmd_we;
   logic [ADDR_W-1:0] r_cmd_addr;
   logic [DATA_W-1:0] r_cmd_wdata;
   logic              r_cmd_grant;
   logic              r_last_served;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              w_grant_valid;
   logic              w_grant_idx;

   rr_arbiter_2 u_pick (
      .i_req0        (req0),
      .i_req1        (req1),
      .i_last_served (r_last_served),
      .i_rr_en       (RR_EN),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and decoded outputs; memory pins are only live in ACCESS.
   always_comb begin
      w_next_state    = ARB_IDLE;
      busy            = 1'b1;
      ack0            = 1'b0;
      ack1            = 1'b0;
      mem_access_addr = '0;
      mem_write_data  = '0;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            busy         = 1'b0;
            w_next_state = w_grant_valid ? ARB_ACCESS : ARB_IDLE;
         end
         ARB_ACCESS: begin
            w_next_state    = ARB_RESP;
            mem_access_addr = r_cmd_addr;
            mem_write_data  = r_cmd_wdata;
            mem_write_en    = r_cmd_we;
            mem_read        = ~r_cmd_we;
         end
         ARB_RESP: begin
            w_next_state = ARB_IDLE;
            ack0         = ~r_cmd_grant;
            ack1         = r_cmd_grant;
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   // Latch the winning command when a grant is taken from IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_cmd_grant <= 1'b0;
      end else if (r_state == ARB_IDLE && w_grant_valid) begin
         r_cmd_grant <= w_grant_idx;
         r_cmd_we    <= w_grant_idx ? we1    : we0;
         r_cmd_addr  <= w_grant_idx ? addr1  : addr0;
         r_cmd_wdata <= w_grant_idx ? wdata1 : wdata0;
      end
   end

   // Capture read data and record the served port at the end of ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_served <= 1'b1;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
      end else if (r_state == ARB_ACCESS) begin
         r_last_served <= r_cmd_grant;
         if (!r_cmd_we && !r_cmd_grant) r_rdata0 <= mem_read_data;
         if (!r_cmd_we &&  r_cmd_grant) r_rdata1 <= mem_read_data;
      end
   end

   assign rdata0 = r_rdata0;
   assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: transaction-schedule reference model, directed
// scenarios with literal expectations, and randomized two-port traffic.
module tb_data_mem_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Round-robin instance signals
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, busy, mem_write_en, mem_read;
   logic [DW-1:0] rdata0, rdata1, mem_write_data, mem_read_data;
   logic [AW-1:0] mem_access_addr;
   logic [DW-1:0] mem [0:15];

   // Fixed-priority instance signals
   logic          f_req0, f_req1, f_we0, f_we1;
   logic [AW-1:0] f_addr0, f_addr1;
   logic [DW-1:0] f_wdata0, f_wdata1;
   logic          f_ack0, f_ack1, f_busy, f_mem_write_en, f_mem_read;
   logic [DW-1:0] f_rdata0, f_rdata1, f_mem_write_data, f_mem_read_data;
   logic [AW-1:0] f_mem_access_addr;
   logic [DW-1:0] f_mem [0:15];

   data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0(f_req0), .req1(f_req1), .we0(f_we0), .we1(f_we1),
      .addr0(f_addr0), .addr1(f_addr1), .wdata0(f_wdata0), .wdata1(f_wdata1),
      .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1), .busy(f_busy),
      .mem_access_addr(f_mem_access_addr), .mem_write_data(f_mem_write_data),
      .mem_write_en(f_mem_write_en), .mem_read(f_mem_read), .mem_read_data(f_mem_read_data)
   );

   // DataMem stand-ins: combinational read, write on posedge
   assign mem_read_data   = mem[mem_access_addr[3:0]];
   assign f_mem_read_data = f_mem[f_mem_access_addr[3:0]];
   always @(posedge clk) if (mem_write_en) mem[mem_access_addr[3:0]] <= mem_write_data;
   always @(posedge clk) if (f_mem_write_en) f_mem[f_mem_access_addr[3:0]] <= f_mem_write_data;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted request owns the three cycles starting at
   // its grant edge; access in the first, ack in the second. A new grant is only
   // possible three or more edges after the previous one.
   int            edge_n     = 0;
   int            start_edge = -100;
   int            m_port     = 0;
   logic          m_we       = 1'b0;
   logic [AW-1:0] m_addr     = '0;
   logic [DW-1:0] m_wdata    = '0;
   logic          m_last     = 1'b1;
   logic [DW-1:0] model_mem [0:15];
   logic [DW-1:0] m_rdata [2];
   logic          chk_en = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         start_edge = -100;
         m_last     = 1'b1;
         m_rdata[0] = '0;
         m_rdata[1] = '0;
      end else begin
         edge_n++;
         if (edge_n - start_edge == 1) begin
            if (m_we) model_mem[m_addr[3:0]] = m_wdata;
            else      m_rdata[m_port] = model_mem[m_addr[3:0]];
         end
         if (edge_n - start_edge >= 3 && (req0 || req1)) begin
            if (req0 && req1) m_port = (m_last == 1'b1) ? 0 : 1;
            else              m_port = req1 ? 1 : 0;
            m_last     = (m_port == 1);
            m_we       = (m_port == 1) ? we1    : we0;
            m_addr     = (m_port == 1) ? addr1  : addr0;
            m_wdata    = (m_port == 1) ? wdata1 : wdata0;
            start_edge = edge_n;
         end
      end
   end

   int k;
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         k = edge_n - start_edge;
         check("busy",         busy,            k >= 0 && k < 2);
         check("mem_write_en", mem_write_en,    k == 0 && m_we);
         check("mem_read",     mem_read,        k == 0 && !m_we);
         check("mem_addr",     mem_access_addr, (k == 0) ? m_addr : '0);
         check("mem_wdata",    mem_write_data,  (k == 0) ? m_wdata : '0);
         check("ack0",         ack0,            k == 1 && m_port == 0);
         check("ack1",         ack1,            k == 1 && m_port == 1);
         check("rdata0",       rdata0,          m_rdata[0]);
         check("rdata1",       rdata1,          m_rdata[1]);
      end
   end

   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   // Random requester: issue n commands, hold each until its ack.
   task automatic drive_port(input int p, input int n);
      for (int t = 0; t < n; t++) begin
         int   gap;
         logic got;
         gap = $urandom_range(0, 3);
         set_port(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
         got = 1'b0;
         for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? ack0 : ack1) got = 1'b1;
         end
         check($sformatf("ack_wait_p%0d", p), got, 1'b1);
         @(posedge clk); #1;
         if (p == 0) req0 = 1'b0; else req1 = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1 rst = 1'b1;
      #1;
      check("rst_busy",  busy,  1'b0);
      check("rst_ack",   {ack0, ack1}, 2'b00);
      check("rst_rdata", {rdata0, rdata1}, 32'h0);
      check("rst_mem",   {mem_write_en, mem_read, mem_access_addr}, '0);
      @(posedge clk); @(negedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      int            order[$];
      int            tim[$];
      logic [DW-1:0] saved5;
      int            cnt0, cnt1;
      logic          got;

      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      f_req0 = 0; f_req1 = 0; f_we0 = 0; f_we1 = 0; f_addr0 = '0; f_addr1 = '0;
      f_wdata0 = '0; f_wdata1 = '0;
      for (int i = 0; i < 16; i++) begin
         mem[i]       = DW'($urandom);
         model_mem[i] = mem[i];
         f_mem[i]     = DW'($urandom);
      end
      #2;
      check("reset_busy",  busy, 1'b0);
      check("reset_outs",  {ack0, ack1, mem_write_en, mem_read}, 4'b0000);
      check("reset_bus",   {mem_access_addr, mem_write_data}, 32'h0);
      check("reset_rdata", {rdata0, rdata1}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst = 1'b0;
      chk_en = 1'b1;

      // Single write of BEEF to address 3
      @(posedge clk); #1 set_port(0, 1'b1, 1'b1, 16'd3, 16'hBEEF);
      @(negedge clk);
      check("wr_idle_busy", busy, 1'b0);
      @(negedge clk);
      check("wr_access", {mem_write_en, mem_read, mem_access_addr, mem_write_data},
            {2'b10, 16'd3, 16'hBEEF} );
      @(negedge clk);
      check("wr_ack", {ack0, ack1, mem_write_en}, 3'b100);
      check("wr_mem3", mem[3], 16'hBEEF);
      @(posedge clk); #1 set_port(0, 1'b1, 1'b0, 16'd3, 16'h0);
      @(negedge clk); @(negedge clk);
      check("rd_access", {mem_write_en, mem_read, mem_access_addr}, {2'b01, 16'd3});
      @(negedge clk);
      check("rd_ack",   {ack0, ack1}, 2'b10);
      check("rd_rdata", rdata0, 16'hBEEF);
      @(posedge clk); #1 req0 = 1'b0;
      repeat (2) @(posedge clk);

      // Mid-cycle reset clears held read data; then a tie held for 4 transactions
      pulse_reset();
      @(posedge clk); #1;
      set_port(0, 1'b1, 1'b0, 16'd3, '0);
      set_port(1, 1'b1, 1'b0, 16'd7, '0);
      for (int c = 0; c < 30 && order.size() < 4; c++) begin
         @(negedge clk);
         if (ack0) begin order.push_back(0); tim.push_back(c); end
         if (ack1) begin order.push_back(1); tim.push_back(c); end
      end
      check("tie_ack_count", order.size(), 4);
      if (order.size() == 4) begin
         check("tie_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]},
               8'b00_01_00_01);
         check("tie_first_latency", tim[0], 2);
         check("tie_ack_spacing", tim[1] - tim[0], 3);
         check("tie_rdata1", rdata1, mem[7]);
      end
      @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);

      // Reset during the ACCESS cycle of a write must not commit it
      saved5 = mem[5];
      @(posedge clk); #1 set_port(0, 1'b1, 1'b1, 16'd5, 16'h1234);
      @(negedge clk); @(negedge clk);
      check("rst_wr_access", mem_write_en, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("rst_wr_we_drop", {mem_write_en, busy, ack0}, 3'b000);
      req0 = 1'b0;
      @(posedge clk); @(negedge clk); #1 rst = 1'b0;
      cnt0 = 0;
      repeat (5) begin @(negedge clk); if (ack0) cnt0++; end
      check("rst_wr_no_ack", cnt0, 0);
      check("rst_wr_mem5", mem[5], saved5);

      // Randomized traffic on both ports
      fork
         drive_port(0, 30);
         drive_port(1, 30);
      join
      repeat (4) @(posedge clk);
      for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], model_mem[i]);

      // Fixed priority: port 0 always wins while held
      @(posedge clk); #1;
      f_req0 = 1'b1; f_we0 = 1'b0; f_addr0 = 16'd1;
      f_req1 = 1'b1; f_we1 = 1'b0; f_addr1 = 16'd2;
      cnt0 = 0; cnt1 = 0;
      repeat (12) begin
         @(negedge clk);
         if (f_ack0) cnt0++;
         if (f_ack1) cnt1++;
      end
      check("fp_ack0_count", cnt0, 4);
      check("fp_ack1_count", cnt1, 0);
      check("fp_rdata0", f_rdata0, f_mem[1]);
      @(posedge clk); #1 f_req0 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 3 && !got; i++) begin
         @(negedge clk);
         if (f_ack1) got = 1'b1;
      end
      check("fp_port1_served", got, 1'b1);
      check("fp_rdata1", f_rdata1, f_mem[2]);
      @(posedge clk); #1 f_req1 = 1'b0;
      repeat (3) @(posedge clk);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
